// File: rtl/taxi_axis_pipeline_fifo_pkg.sv
// rtl/taxi_axis_pipeline_fifo_pkg.sv - sizing helpers for the long-haul stream pipeline
package taxi_axis_pipeline_fifo_pkg;

  // Output FIFO must hold the 2*LENGTH beats still in flight after ready drops, plus margin.
  function automatic int fifo_depth_w(input int length);
    return $clog2(2 * length + 2);
  endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// rtl/taxi_axis_if.sv - AXI4-Stream bundle with optional sidebands
interface taxi_axis_if #(
  parameter int DATA_W  = 8,
  parameter bit KEEP_EN = DATA_W > 8,
  parameter int KEEP_W  = (DATA_W + 7) / 8,
  parameter bit STRB_EN = 1'b0,
  parameter bit LAST_EN = 1'b1,
  parameter bit ID_EN   = 1'b0,
  parameter int ID_W    = 8,
  parameter bit DEST_EN = 1'b0,
  parameter int DEST_W  = 8,
  parameter bit USER_EN = 1'b0,
  parameter int USER_W  = 1
) ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;

  modport src (
    output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
    input  tready
  );

  modport snk (
    input  tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/taxi_axis_pipeline_fifo.sv
// rtl/taxi_axis_pipeline_fifo.sv - long-haul AXI-Stream pipeline: registered data and ready chains feeding an output FIFO
module taxi_axis_pipeline_fifo
  import taxi_axis_pipeline_fifo_pkg::*;
#(
  parameter int  LENGTH       = 2,
  localparam int FIFO_DEPTH_W = fifo_depth_w(LENGTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  taxi_axis_if.snk                s_axis,
  taxi_axis_if.src                m_axis,
  output logic [FIFO_DEPTH_W+1:0] status_depth,
  output logic                    status_overflow
);
  localparam int DATA_W   = s_axis.DATA_W;
  localparam int KEEP_W   = s_axis.KEEP_W;
  localparam int ID_W     = s_axis.ID_W;
  localparam int DEST_W   = s_axis.DEST_W;
  localparam int USER_W   = s_axis.USER_W;
  localparam int M_ID_W   = m_axis.ID_W;
  localparam int M_DEST_W = m_axis.DEST_W;
  localparam int M_USER_W = m_axis.USER_W;

  localparam bit KEEP_EN = s_axis.KEEP_EN && m_axis.KEEP_EN;
  localparam bit STRB_EN = s_axis.STRB_EN && m_axis.STRB_EN;
  localparam bit LAST_EN = s_axis.LAST_EN && m_axis.LAST_EN;
  localparam bit ID_EN   = s_axis.ID_EN && m_axis.ID_EN;
  localparam bit DEST_EN = s_axis.DEST_EN && m_axis.DEST_EN;
  localparam bit USER_EN = s_axis.USER_EN && m_axis.USER_EN;

  if (m_axis.DATA_W != DATA_W || m_axis.KEEP_W != KEEP_W) begin : g_width_check
    $fatal(1, "taxi_axis_pipeline_fifo: s_axis and m_axis DATA_W/KEEP_W differ");
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [KEEP_W-1:0] strb;
    logic              last;
    logic [ID_W-1:0]   id;
    logic [DEST_W-1:0] dest;
    logic [USER_W-1:0] user;
  } beat_t;

  beat_t in_beat;
  beat_t out_beat;
  logic  out_valid;

  // Sidebands not enabled on both ends are zeroed at entry so they never reach m_axis.
  always_comb begin
    in_beat      = '0;
    in_beat.data = s_axis.tdata;
    in_beat.keep = KEEP_EN ? s_axis.tkeep : '0;
    in_beat.strb = STRB_EN ? s_axis.tstrb : '0;
    in_beat.last = LAST_EN ? s_axis.tlast : 1'b0;
    in_beat.id   = ID_EN   ? s_axis.tid   : '0;
    in_beat.dest = DEST_EN ? s_axis.tdest : '0;
    in_beat.user = USER_EN ? s_axis.tuser : '0;
  end

  assign m_axis.tdata  = out_beat.data;
  assign m_axis.tkeep  = out_beat.keep;
  assign m_axis.tstrb  = out_beat.strb;
  assign m_axis.tlast  = out_beat.last;
  assign m_axis.tid    = M_ID_W'(out_beat.id);
  assign m_axis.tdest  = M_DEST_W'(out_beat.dest);
  assign m_axis.tuser  = M_USER_W'(out_beat.user);
  assign m_axis.tvalid = out_valid;

  if (LENGTH == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass     = clk ^ rst;
    assign out_beat        = in_beat;
    assign out_valid       = s_axis.tvalid;
    assign s_axis.tready   = m_axis.tready;
    assign status_depth    = '0;
    assign status_overflow = 1'b0;
  end else begin : g_pipe
    localparam int FIFO_DEPTH = 2 ** FIFO_DEPTH_W;
    localparam int PTR_W      = FIFO_DEPTH_W + 1;
    localparam int STAT_W     = FIFO_DEPTH_W + 2;
    localparam logic [PTR_W-1:0] READY_LIMIT = PTR_W'(FIFO_DEPTH - 2 * LENGTH);

    beat_t [LENGTH-1:0] pipe_data_q, pipe_data_d;
    logic  [LENGTH-1:0] pipe_valid_q, pipe_valid_d;
    logic  [LENGTH-1:0] ready_q, ready_d;
    beat_t              mem [FIFO_DEPTH];
    logic  [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_count;
    beat_t              out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               overflow_q, overflow_d;
    logic               fifo_full, fifo_empty, wr_en, rd_en, ready_int;
    logic  [STAT_W-1:0] depth;

    assign pipe_valid_d[0] = s_axis.tvalid && ready_q[LENGTH-1];
    assign pipe_data_d[0]  = in_beat;
    assign ready_d[0]      = ready_int;

    for (genvar k = 1; k < LENGTH; k++) begin : g_stage
      assign pipe_valid_d[k] = pipe_valid_q[k-1];
      assign pipe_data_d[k]  = pipe_data_q[k-1];
      assign ready_d[k]      = ready_q[k-1];
    end

    always_comb begin
      fifo_count  = wr_ptr_q - rd_ptr_q;
      fifo_empty  = wr_ptr_q == rd_ptr_q;
      fifo_full   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
      ready_int   = fifo_count < READY_LIMIT;
      wr_en       = pipe_valid_q[LENGTH-1] && !fifo_full;
      rd_en       = !fifo_empty && (!out_valid_q || m_axis.tready);
      wr_ptr_d    = wr_ptr_q + PTR_W'(wr_en);
      rd_ptr_d    = rd_ptr_q + PTR_W'(rd_en);
      out_valid_d = rd_en || (out_valid_q && !m_axis.tready);
      out_d       = rd_en ? mem[rd_ptr_q[PTR_W-2:0]] : out_q;
      overflow_d  = overflow_q || (pipe_valid_q[LENGTH-1] && fifo_full);
      // Occupancy counts the output register too, so it matches beats accepted minus beats delivered.
      depth = STAT_W'(fifo_count) + STAT_W'(out_valid_q);
      for (int k = 0; k < LENGTH; k++) begin
        depth = depth + STAT_W'(pipe_valid_q[k]);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_valid_q <= '0;
        ready_q      <= '0;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        out_valid_q  <= 1'b0;
        overflow_q   <= 1'b0;
      end else begin
        pipe_valid_q <= pipe_valid_d;
        ready_q      <= ready_d;
        wr_ptr_q     <= wr_ptr_d;
        rd_ptr_q     <= rd_ptr_d;
        out_valid_q  <= out_valid_d;
        overflow_q   <= overflow_d;
      end
    end

    always_ff @(posedge clk) begin
      pipe_data_q <= pipe_data_d;
      out_q       <= out_d;
      if (wr_en) begin
        mem[wr_ptr_q[PTR_W-2:0]] <= pipe_data_q[LENGTH-1];
      end
    end

    assign out_beat        = out_q;
    assign out_valid       = out_valid_q;
    assign s_axis.tready   = ready_q[LENGTH-1];
    assign status_depth    = depth;
    assign status_overflow = overflow_q;
  end

endmodule

// File: tb/tb_taxi_axis_pipeline_fifo.sv
// tb/tb_taxi_axis_pipeline_fifo.sv - bench for taxi_axis_pipeline_fifo (LENGTH=3 with sidebands, LENGTH=0 pass-through)
module tb_taxi_axis_pipeline_fifo;
  localparam int L     = 3;
  localparam int DEPTH = 8;

  typedef logic [29:0] beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] status_depth;
  logic       status_overflow;
  logic [2:0] status0_depth;
  logic       status0_overflow;

  int    n_assert  = 0;
  int    n_fail    = 0;
  int    n_in      = 0;
  int    n_out     = 0;
  int    max_depth = 0;
  int    start     = 0;
  int    cyc       = 0;
  bit    hold      = 1'b0;
  beat_t sb[$];

  always #5 clk = ~clk;

  taxi_axis_if #(.DATA_W(16), .KEEP_EN(1), .KEEP_W(2), .STRB_EN(1), .LAST_EN(1), .ID_EN(1), .ID_W(4),
                 .DEST_EN(1), .DEST_W(3), .USER_EN(1), .USER_W(2)) s_if ();
  taxi_axis_if #(.DATA_W(16), .KEEP_EN(1), .KEEP_W(2), .STRB_EN(1), .LAST_EN(1), .ID_EN(1), .ID_W(4),
                 .DEST_EN(1), .DEST_W(3), .USER_EN(1), .USER_W(2)) m_if ();
  taxi_axis_if #(.DATA_W(16), .KEEP_EN(1), .KEEP_W(2), .STRB_EN(1), .LAST_EN(1), .ID_EN(1), .ID_W(4),
                 .DEST_EN(1), .DEST_W(3), .USER_EN(1), .USER_W(2)) s0_if ();
  taxi_axis_if #(.DATA_W(16), .KEEP_EN(1), .KEEP_W(2), .STRB_EN(1), .LAST_EN(1), .ID_EN(1), .ID_W(4),
                 .DEST_EN(1), .DEST_W(3), .USER_EN(0), .USER_W(2)) m0_if ();

  taxi_axis_pipeline_fifo #(.LENGTH(L)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .status_depth    (status_depth),
    .status_overflow (status_overflow)
  );

  taxi_axis_pipeline_fifo #(.LENGTH(0)) u_dut0 (
    .clk             (clk),
    .rst             (rst),
    .s_axis          (s0_if),
    .m_axis          (m0_if),
    .status_depth    (status0_depth),
    .status_overflow (status0_overflow)
  );

  function automatic beat_t pack_s();
    return {s_if.tdata, s_if.tkeep, s_if.tstrb, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser};
  endfunction

  function automatic beat_t pack_m();
    return {m_if.tdata, m_if.tkeep, m_if.tstrb, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic, entered and left at a falling edge; pv/pr are valid/ready percentages.
  task automatic cycle(input int pv, input int pr);
    beat_t r, r0, in_b, out_b, exp_b;
    bit    s_hs, m_hs;
    if (!hold) begin
      r = beat_t'($urandom);
      s_if.tvalid = ($urandom_range(99) < pv);
      {s_if.tdata, s_if.tkeep, s_if.tstrb, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser} = r;
    end
    m_if.tready = ($urandom_range(99) < pr);
    r0 = beat_t'($urandom);
    {s0_if.tdata, s0_if.tkeep, s0_if.tstrb, s0_if.tlast, s0_if.tid, s0_if.tdest, s0_if.tuser} = r0;
    s0_if.tvalid = 1'($urandom_range(1));
    m0_if.tready = 1'($urandom_range(1));
    #1;
    check("p0_beat", {m0_if.tdata, m0_if.tkeep, m0_if.tstrb, m0_if.tlast, m0_if.tid, m0_if.tdest, m0_if.tuser},
          r0 & ~30'h3);
    check("p0_valid", m0_if.tvalid, s0_if.tvalid);
    check("p0_ready", s0_if.tready, m0_if.tready);
    check("p0_status", {status0_overflow, status0_depth}, 0);
    s_hs  = s_if.tvalid && s_if.tready;
    m_hs  = m_if.tvalid && m_if.tready;
    in_b  = pack_s();
    out_b = pack_m();
    @(posedge clk);
    if (s_hs) begin
      sb.push_back(in_b);
      n_in++;
    end
    if (m_hs) begin
      n_out++;
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        check("beat", out_b, exp_b);
      end
    end
    hold = s_if.tvalid && !s_hs;
    @(negedge clk);
    check("depth", status_depth, sb.size());
    check("overflow", status_overflow, 0);
    if (int'(status_depth) > max_depth) max_depth = int'(status_depth);
  endtask

  task automatic release_and_check_ready();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rdy_0", s_if.tready, 0);
    for (int k = 1; k <= L; k++) begin
      @(posedge clk);
      #1;
      check("rst_rdy_seq", s_if.tready, (k >= L));
    end
    @(negedge clk);
  endtask

  initial begin
    {s_if.tdata, s_if.tkeep, s_if.tstrb, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser} = '0;
    s_if.tvalid  = 1'b0;
    m_if.tready  = 1'b0;
    {s0_if.tdata, s0_if.tkeep, s0_if.tstrb, s0_if.tlast, s0_if.tid, s0_if.tdest, s0_if.tuser} = '0;
    s0_if.tvalid = 1'b0;
    m0_if.tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_tready", s_if.tready, 0);
    check("rst_depth", status_depth, 0);
    check("rst_overflow", status_overflow, 0);
    release_and_check_ready();

    // Latency: single beat, empty FIFO, output ready
    s_if.tdata  = 16'h00A5;
    s_if.tkeep  = 2'b11;
    s_if.tstrb  = 2'b01;
    s_if.tlast  = 1'b1;
    s_if.tid    = 4'h9;
    s_if.tdest  = 3'h5;
    s_if.tuser  = 2'h2;
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    #1;
    check("lat_src_ready", s_if.tready, 1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      check("lat_wait_tvalid", m_if.tvalid, 0);
      check("lat_wait_depth", status_depth, 1);
      @(posedge clk);
    end
    @(negedge clk);
    check("lat_tvalid", m_if.tvalid, 1);
    check("lat_tdata", m_if.tdata, 16'h00A5);
    check("lat_tlast", m_if.tlast, 1);
    check("lat_side", {m_if.tkeep, m_if.tstrb, m_if.tid, m_if.tdest, m_if.tuser}, {2'b11, 2'b01, 4'h9, 3'h5, 2'h2});
    check("lat_depth", status_depth, 1);
    @(posedge clk);
    @(negedge clk);
    check("lat_done_tvalid", m_if.tvalid, 0);
    check("lat_done_depth", status_depth, 0);

    // Streaming at full rate
    start = n_in;
    repeat (1000) cycle(100, 100);
    check("stream_accepted", n_in - start, 1000);
    check("stream_inflight", sb.size(), L + 2);
    repeat (20) cycle(0, 100);
    check("stream_drained", sb.size(), 0);

    // Backpressure with source always valid
    max_depth = 0;
    repeat (40) cycle(100, 0);
    check("bp_tready_low", s_if.tready, 0);
    check("bp_filled", sb.size() >= 5, 1);
    check("bp_bound", max_depth <= DEPTH + L + 1, 1);
    repeat (40) cycle(0, 100);
    check("bp_drained", sb.size(), 0);

    // Reset mid-burst with beats held
    repeat (30) cycle(100, 0);
    check("rst_mid_fill", sb.size() >= 5, 1);
    #2;
    rst         = 1'b1;
    s_if.tvalid = 1'b0;
    hold        = 1'b0;
    #1;
    check("rst_mid_tvalid", m_if.tvalid, 0);
    check("rst_mid_depth", status_depth, 0);
    check("rst_mid_tready", s_if.tready, 0);
    check("rst_mid_overflow", status_overflow, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    release_and_check_ready();
    start = n_in;
    repeat (50) cycle(100, 100);
    check("rst_post_stream", n_in - start, 50);
    repeat (20) cycle(0, 100);
    check("rst_post_drained", sb.size(), 0);

    // Random valid/ready at 50%
    start = n_in;
    cyc   = 0;
    while ((n_in - start) < 10000 && cyc < 60000) begin
      cycle(50, 50);
      cyc++;
    end
    check("rand_beats", (n_in - start) >= 10000, 1);
    repeat (60) cycle(0, 100);
    check("rand_drained", sb.size(), 0);
    check("rand_overflow", status_overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
